counter_timer: RTL and testbench
================================

Name: counter_timer

Overview:
Parametrised successor of the basic 0-to-MAX counter. Provides a configurable-width timer/counter with runtime limit, up/down direction, one-shot or auto-reload mode, explicit start/stop/clear control, a sticky finished flag and a single-cycle terminal pulse. Used as the general timing primitive for delays, debouncing and periodic ticks in the design.

Parameters:
WIDTH, 11, bit width of the counter and limit (11 covers 0..2000)
PRESCALE_WIDTH, 8, width of the prescale divider value (used only with the optional feature)

Ports:
clock_i  input  1  clock, all logic on rising edge
reset_i  input  1  synchronous, active-high reset
enable_i  input  1  count qualifier; a step can occur only in cycles with enable_i=1
start_i  input  1  latch configuration and (re)start counting
stop_i  input  1  abort counting, return to IDLE
clear_i  input  1  clear finished_o; leaves DONE for IDLE
mode_reload_i  input  1  0 = one-shot, 1 = auto-reload (sampled at start)
dir_down_i  input  1  0 = count up 0->limit, 1 = count down limit->0 (sampled at start)
limit_i  input  WIDTH  terminal value (up) or start value (down) (sampled at start)
prescale_i  input  PRESCALE_WIDTH  step every prescale_i+1 enabled cycles (present only with COUNTER_PRESCALER_EN)
counter_val_o  output  WIDTH  current count, registered
busy_o  output  1  high while in RUN
finished_o  output  1  sticky one-shot completion flag
tick_o  output  1  one-cycle pulse on each terminal event

Behaviour:
- Reset (reset_i=1 at a clock edge): state IDLE; counter_val_o=0, busy_o=0, finished_o=0, tick_o=0; latched configuration cleared to 0.
- States: IDLE, RUN, DONE. busy_o=1 exactly in RUN.
- Priority per cycle: reset_i > stop_i > start_i > step > clear_i.
- IDLE: counter holds 0. start_i -> latch limit/dir/mode; counter loads 0 (up) or limit (down); finished_o cleared; go RUN next cycle. No step is taken in the start cycle.
- RUN: step = enable_i (with prescaler: enable_i and prescale terminal). On a step:
  - terminal (up: count==limit; down: count==0) -> tick_o=1 next cycle; reload mode: counter reloads start value, stay RUN; one-shot mode: finished_o<=1, counter holds terminal value, go DONE.
  - otherwise count +1 (up) or -1 (down). No wrap-around beyond limit/0 ever occurs.
- Without a step the counter holds. enable_i low has no other effect.
- limit=0: terminal is detected on the first step; period = 1 step.
- Reload period = limit+1 steps (terminal value included).
- stop_i in RUN or DONE: go IDLE, counter<=0, no tick_o, finished_o unchanged.
- start_i in RUN/DONE: restart as from IDLE (reload counter, clear finished_o, re-latch configuration).
- clear_i: finished_o<=0; in DONE -> IDLE with counter<=0. If clear_i coincides with a finishing step, the set wins.
- Input changes to limit_i/dir_down_i/mode_reload_i outside start cycles are ignored.
- tick_o and finished_o are registered: asserted in the cycle after the terminal step.

Optional Feature:
COUNTER_PRESCALER_EN. Defined: prescale_i port exists; an internal PRESCALE_WIDTH counter advances on enabled RUN cycles and produces a step every prescale_i+1 enabled cycles; it is cleared on reset, start, stop and on each produced step; prescale_i is latched at start. Undefined: prescale_i port and prescaler logic are absent; every enabled RUN cycle is a step.

Decomposition:
- Shared package/header counter_pkg: state encoding constants STATE_IDLE=2'd0, STATE_RUN=2'd1, STATE_DONE=2'd2, state width 2, mode/direction constants.
- One sub-module: counter_prescaler (enable in, clear in, divide value in, step pulse out), instantiated only under COUNTER_PRESCALER_EN.

Test Plan:
- Reset with all inputs high -> counter_val_o=0, busy_o=0, finished_o=0, tick_o=0 on the cycle after reset.
- Up, one-shot, limit=5, enable_i constantly high -> counts 0..5; the 6th step (at 5) gives tick_o and finished_o=1 the cycle after; state DONE, counter holds 5.
- Down, reload, limit=3, enable toggling 1/0 -> sequence 3,2,1,0,3,...; tick_o once per 4 steps; finished_o stays 0.
- limit=0, up, one-shot -> finished_o and tick_o one cycle after the first step.
- stop_i mid-run at count 7 of limit 10 -> IDLE, counter 0, no tick_o; clear_i coinciding with a finishing step -> finished_o=1.
- COUNTER_PRESCALER_EN, prescale_i=2, limit=2, up -> counter advances every 3 enabled cycles; finishes after 9 enabled cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and mode/direction constants for counter_timer
package counter_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] STATE_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] STATE_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] STATE_DONE = 2'd2;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = STATE_IDLE,
    S_RUN  = STATE_RUN,
    S_DONE = STATE_DONE
  } state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits a step every div+1 enabled cycles; ports clk, rst, en, clr, div in, step out
module counter_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         step
);
  logic [W-1:0] cnt;
  assign step = en && (cnt == div);
  always_ff @(posedge clk) begin
    if (rst || clr || step) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/counter_timer.sv
// counter_timer: up/down one-shot/reload timer with start/stop/clear, sticky finished_o and tick_o pulse.
// Ports: clock_i, reset_i (sync, active-high), enable_i, start_i, stop_i, clear_i, mode_reload_i,
// dir_down_i, limit_i[WIDTH], prescale_i[PRESCALE_WIDTH] (only with COUNTER_PRESCALER_EN),
// counter_val_o, busy_o, finished_o, tick_o. Define COUNTER_PRESCALER_EN to add the step prescaler.
module counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH          = 11,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      clear_i,
  input  logic                      mode_reload_i,
  input  logic                      dir_down_i,
  input  logic [WIDTH-1:0]          limit_i,
`ifdef COUNTER_PRESCALER_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
`endif
  output logic [WIDTH-1:0]          counter_val_o,
  output logic                      busy_o,
  output logic                      finished_o,
  output logic                      tick_o
);
  state_t state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, lim, lim_n;
  logic dir, dir_n, mode, mode_n, fin, fin_n, tk, tk_n, step, term;
`ifdef COUNTER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] pdiv;
  always_ff @(posedge clock_i) begin
    if (reset_i) pdiv <= '0;
    else if (start_i && !stop_i) pdiv <= prescale_i;
  end
  counter_prescaler #(.W(PRESCALE_WIDTH)) u_pre (
    .clk(clock_i),
    .rst(reset_i),
    .en(state == S_RUN && enable_i),
    .clr(start_i || stop_i),
    .div(pdiv),
    .step(step)
  );
`else
  assign step = (state == S_RUN) && enable_i;
`endif
  assign term = (dir == DIR_DOWN) ? (cnt == '0) : (cnt == lim);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lim_n   = lim;
    dir_n   = dir;
    mode_n  = mode;
    fin_n   = fin;
    tk_n    = 1'b0;
    if (stop_i) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else if (start_i) begin
      lim_n   = limit_i;
      dir_n   = dir_down_i;
      mode_n  = mode_reload_i;
      cnt_n   = dir_down_i ? limit_i : '0;
      fin_n   = 1'b0;
      state_n = S_RUN;
    end else begin
      if (clear_i) begin
        fin_n = 1'b0;
        if (state == S_DONE) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      // a finishing step overrides a coincident clear
      if (step && term) begin
        tk_n = 1'b1;
        if (mode == MODE_RELOAD) cnt_n = (dir == DIR_DOWN) ? lim : '0;
        else begin
          fin_n   = 1'b1;
          state_n = S_DONE;
        end
      end else if (step) cnt_n = (dir == DIR_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      lim   <= '0;
      dir   <= 1'b0;
      mode  <= 1'b0;
      fin   <= 1'b0;
      tk    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lim   <= lim_n;
      dir   <= dir_n;
      mode  <= mode_n;
      fin   <= fin_n;
      tk    <= tk_n;
    end
  end
  assign counter_val_o = cnt;
  assign busy_o        = (state == S_RUN);
  assign finished_o    = fin;
  assign tick_o        = tk;
endmodule

// File: tb/tb_counter_timer.sv
// tb_counter_timer: randomized self-checking bench for counter_timer against a step-count reference model
module tb_counter_timer;
  localparam int WIDTH = 11;
  localparam int PW    = 8;
  logic clock_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0;
  logic mode_reload_i = 1'b0, dir_down_i = 1'b0;
  logic [WIDTH-1:0] limit_i = '0;
  logic [PW-1:0] prescale_i = '0;
  logic [WIDTH-1:0] counter_val_o;
  logic busy_o, finished_o, tick_o;
  int checks = 0, fails = 0;
  // model: phase 0 idle, 1 run, 2 done; n = steps since start
  int mst = 0, n = 0, ml = 0, pre = 0, pdiv = 0;
  bit md = 0, mm = 0, mfin = 0, mtick = 0;
  counter_timer #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .clear_i(clear_i),
    .mode_reload_i(mode_reload_i),
    .dir_down_i(dir_down_i),
    .limit_i(limit_i),
`ifdef COUNTER_PRESCALER_EN
    .prescale_i(prescale_i),
`endif
    .counter_val_o(counter_val_o),
    .busy_o(busy_o),
    .finished_o(finished_o),
    .tick_o(tick_o)
  );
  always #5 clock_i = ~clock_i;
  function automatic logic [WIDTH+2:0] expv();
    int v;
    if (mst == 0) v = 0;
    else if (mst == 2) v = md ? 0 : ml;
    else v = md ? ml - (n % (ml + 1)) : n % (ml + 1);
    return {v[WIDTH-1:0], mst == 1, mfin, mtick};
  endfunction
  function automatic logic [WIDTH+2:0] gotv();
    return {counter_val_o, busy_o, finished_o, tick_o};
  endfunction
  task automatic drive(input bit en, input bit st, input bit sp, input bit cl);
    bit s;
    enable_i = en; start_i = st; stop_i = sp; clear_i = cl;
    @(posedge clock_i);
    mtick = 0;
    if (sp) begin
      mst = 0; n = 0;
    end else if (st) begin
      ml = int'(limit_i); md = dir_down_i; mm = mode_reload_i; mst = 1; n = 0; mfin = 0; pre = 0;
      pdiv = int'(prescale_i);
    end else begin
      if (cl) begin
        mfin = 0;
        if (mst == 2) mst = 0;
      end
      s = 0;
      if (mst == 1 && en) begin
`ifdef COUNTER_PRESCALER_EN
        pre++;
        if (pre == pdiv + 1) begin s = 1; pre = 0; end
`else
        s = 1;
`endif
      end
      if (s) begin
        n++;
        if (n % (ml + 1) == 0) begin
          mtick = 1;
          if (!mm) begin mst = 2; mfin = 1; end
        end
      end
    end
    #1;
    enable_i = 0; start_i = 0; stop_i = 0; clear_i = 0;
  endtask
  task automatic setcfg(input int l, input bit d, input bit m);
    limit_i = WIDTH'(l); dir_down_i = d; mode_reload_i = m;
  endtask
  task automatic test_reset();
    reset_i = 1; enable_i = 1; start_i = 1; stop_i = 1; clear_i = 1; mode_reload_i = 1; dir_down_i = 1;
    limit_i = '1; prescale_i = '1;
    repeat (2) @(posedge clock_i);
    #1;
    checks++;
    if (gotv() !== '0) begin fails++; $display("FAIL reset got=%h exp=0", gotv()); end
    reset_i = 0; enable_i = 0; start_i = 0; stop_i = 0; clear_i = 0; prescale_i = '0;
    mst = 0; n = 0; mfin = 0; mtick = 0;
    drive(1, 0, 0, 0);
    checks++;
    if (gotv() !== expv()) begin fails++; $display("FAIL idle_after_reset got=%h exp=%h", gotv(), expv()); end
  endtask
  task automatic test_up_oneshot();
    setcfg(5, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (gotv() !== expv()) begin fails++; $display("FAIL up_oneshot cyc=%0d got=%h exp=%h", i, gotv(), expv()); end
    end
    checks++;
    if (counter_val_o !== 11'd5 || finished_o !== 1'b1) begin
      fails++; $display("FAIL up_oneshot_done val=%0d fin=%b exp 5/1", counter_val_o, finished_o);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (gotv() !== expv() || counter_val_o !== '0) begin fails++; $display("FAIL clear_done got=%h exp=%h", gotv(), expv()); end
  endtask
  task automatic test_down_reload();
    int ticks = 0;
    setcfg(3, 1, 1);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive(i % 2 == 0, 0, 0, 0);
      ticks += tick_o;
      checks++;
      if (gotv() !== expv()) begin fails++; $display("FAIL down_reload cyc=%0d got=%h exp=%h", i, gotv(), expv()); end
    end
    checks++;
    if (ticks !== 4) begin fails++; $display("FAIL down_reload_ticks got=%0d exp=4", ticks); end
  endtask
  task automatic test_limit_zero();
    setcfg(0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (gotv() !== expv()) begin fails++; $display("FAIL limit_zero cyc=%0d got=%h exp=%h", i, gotv(), expv()); end
    end
  endtask
  task automatic test_stop_clear();
    setcfg(10, 0, 0);
    drive(0, 1, 0, 0);
    repeat (7) drive(1, 0, 0, 0);
    checks++;
    if (counter_val_o !== 11'd7) begin fails++; $display("FAIL stop_pre got=%0d exp=7", counter_val_o); end
    drive(1, 0, 1, 0);
    checks++;
    if (gotv() !== expv() || gotv() !== '0) begin fails++; $display("FAIL stop got=%h exp=%h", gotv(), expv()); end
    setcfg(2, 0, 0);
    drive(0, 1, 0, 0);
    repeat (2) drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    checks++;
    if (gotv() !== expv() || finished_o !== 1'b1) begin fails++; $display("FAIL clear_vs_finish got=%h exp=%h", gotv(), expv()); end
    drive(1, 0, 1, 0);
    checks++;
    if (gotv() !== expv() || finished_o !== 1'b1) begin fails++; $display("FAIL stop_done_keeps_fin got=%h exp=%h", gotv(), expv()); end
    drive(0, 0, 0, 1);
  endtask
  task automatic test_back_to_back();
    setcfg(6, 0, 1);
    drive(0, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    setcfg(4, 1, 0);
    drive(1, 1, 0, 0);
    checks++;
    if (gotv() !== expv() || counter_val_o !== 11'd4) begin fails++; $display("FAIL restart_run got=%h exp=%h", gotv(), expv()); end
    repeat (6) drive(1, 0, 0, 0);
    setcfg(1, 0, 0);
    drive(1, 1, 0, 0);
    checks++;
    if (gotv() !== expv() || finished_o !== 1'b0) begin fails++; $display("FAIL restart_done got=%h exp=%h", gotv(), expv()); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      setcfg($urandom_range(0, 6), 1'($urandom), 1'($urandom));
      drive(0, 1, 0, 0);
      for (int i = 0; i < 30; i++) begin
        int r = $urandom_range(0, 39);
        setcfg($urandom_range(0, 6), 1'($urandom), 1'($urandom));
        drive(1'($urandom), r == 0, r == 1, r < 5);
        checks++;
        if (gotv() !== expv()) begin fails++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", k, i, gotv(), expv()); end
      end
    end
  endtask
`ifdef COUNTER_PRESCALER_EN
  task automatic test_prescaler();
    setcfg(2, 0, 0);
    prescale_i = 8'd2;
    drive(0, 1, 0, 0);
    prescale_i = 8'd0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (gotv() !== expv()) begin fails++; $display("FAIL prescaler cyc=%0d got=%h exp=%h", i, gotv(), expv()); end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_up_oneshot();
    test_down_reload();
    test_limit_zero();
    test_stop_clear();
    test_back_to_back();
    test_random();
`ifdef COUNTER_PRESCALER_EN
    test_prescaler();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
